mux_rr_arbiter: RTL
===================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum cycles one requester may hold the shared 16:1 mux select; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  16  per-requester request; bit i = requester i wants mux input i routed to the shared output.
REQ-005 done  input  1  current grant holder releases the mux; qualified by gnt_valid.
REQ-006 gnt  output  16  one-hot grant, registered; all zero when no grant.
REQ-007 gnt_valid  output  1  registered; high exactly while gnt is nonzero.
REQ-008 sel  output  4  registered mux select for the shared 16:1 mux; equals index of the set gnt bit while gnt_valid is high.
REQ-009 busy  output  1  registered; high in GRANT state.

Function
REQ-010 The block SHALL be a two-state FSM: IDLE and GRANT.
REQ-011 The block SHALL keep a 4-bit round-robin pointer ptr, the highest-priority index for the next arbitration.
REQ-012 In IDLE with req nonzero, the block SHALL select the first set bit scanning ptr, ptr+1, ... wrapping 15->0.
REQ-013 On that edge it SHALL load gnt (one-hot), sel (index), gnt_valid=1, busy=1, clear the hold counter, and enter GRANT; grant is visible one cycle after req is sampled.
REQ-014 In IDLE with req all zero, the block SHALL stay in IDLE with gnt=0, gnt_valid=0, busy=0, sel held at its last value.
REQ-015 In GRANT, the hold counter SHALL increment by 1 each cycle, saturating at MAX_HOLD.
REQ-016 A grant SHALL be released on the edge where any of these is true: done=1; req[sel]=0; hold counter = MAX_HOLD-1. A grant therefore lasts at most MAX_HOLD cycles.
REQ-017 On release the block SHALL clear gnt, gnt_valid and busy, set ptr = sel+1 mod 16 (15 wraps to 0), and return to IDLE; sel keeps its value.
REQ-018 At least one IDLE cycle SHALL separate consecutive grants; back-to-back grants never overlap and gnt is never more than one-hot.
REQ-019 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-020 If done and a release condition coincide, the block SHALL perform a single release; ptr advances once.
REQ-021 With MAX_HOLD=1, every grant SHALL last exactly one cycle regardless of done.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 With all 16 requesters continuously requesting, grants SHALL rotate 0,1,2,...,15,0 with no requester skipped.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force state=IDLE, gnt=16'h0000, gnt_valid=0, busy=0, sel=4'h0, ptr=4'h0, hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop gnt within the same cycle without waiting for a clock edge; after release of rst_n, arbitration restarts from index 0.
REQ-026 The first rising edge after rst_n deasserts SHALL evaluate req normally, so a grant may appear one cycle after reset release.

Verification
REQ-027 Reset, then req=16'h0001 held with done pulsed on cycle 3 of the grant -> gnt=16'h0001, sel=0 from the edge after req, released after done, ptr=1.
REQ-028 req=16'hFFFF held, done=0, MAX_HOLD=8 -> each grant lasts 8 cycles plus 1 idle cycle; sel sequence 0,1,...,15,0.
REQ-029 ptr=14 (after a grant to 13) and req=16'h0005 -> grant to 0 (wrap), then after release, grant to 2.
REQ-030 Grant to 5 active, req[5] deasserted while req[9]=1 -> gnt drops on next edge, one IDLE cycle, then gnt=16'h0200, sel=9.
REQ-031 Grant to 3 active in cycle 4 of hold, rst_n pulled low between edges -> gnt=0, gnt_valid=0, busy=0 immediately; after release, req=16'h0018 -> grant to 3 (ptr reset to 0).
REQ-032 Throughout all scenarios, check gnt is zero or one-hot, gnt_valid equals |gnt, and sel equals the index of gnt when gnt_valid=1.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant bundle between requesters and the shared-mux arbiter
interface mux_rr_arbiter_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [3:0]  sel;
    logic        busy;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning the select of a shared 16:1 mux, bounded hold time
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic        busy_q, busy_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;

    logic [3:0]  pick;
    logic [3:0]  idx;
    logic        found;
    logic        rel;

    // First requester at or after ptr, wrapping 15 -> 0.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign rel = bus.done || !bus.req[sel_q] || (hold_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        busy_d      = busy_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    gnt_d       = 16'd1 << pick;
                    sel_d       = pick;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    hold_d      = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_MAX)
                    hold_d = hold_q + 8'd1;
                // Any combination of release causes is a single release.
                if (rel) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    ptr_d       = sel_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_q       <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sel       = sel_q;

endmodule
